// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among N requesters,
// with a chip-select guard gap after each transaction and a WAIT timeout.
module spi_arbiter #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic [N-1:0]     reqIn,
  input  logic [N*W-1:0]   txDataIn,
  output logic [N-1:0]     grantOut,
  output logic [N-1:0]     doneOut,
  output logic [N-1:0]     errOut,
  output logic [W-1:0]     rxDataOut,
  output logic             busyOut,
  output logic             spiEnOut,
  output logic [W-1:0]     spiTxDataOut,
  input  logic [W-1:0]     spiRxDataIn,
  input  logic             spiDoneIn,
  output logic [1:0]       dbgState
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  wait_cnt;
  logic [GW-1:0]  gap_cnt;

  logic [2*N-1:0] req_rot_full;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  sel_idx;
  logic           sel_found;
  logic [IW-1:0]  ptr_next;
  logic           timeout_hit;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign req_rot_full = {reqIn, reqIn} >> ptr;
  assign req_rot      = req_rot_full[N-1:0];

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sel_idx   = IW'((int'(ptr) + k) % N);
        sel_found = 1'b1;
      end
    end
  end

  assign ptr_next    = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));
  assign busyOut     = (state != IDLE);
  assign dbgState    = state;

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state        <= IDLE;
      ptr          <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      grantOut     <= '0;
      doneOut      <= '0;
      errOut       <= '0;
      rxDataOut    <= '0;
      spiEnOut     <= 1'b0;
      spiTxDataOut <= '0;
    end else begin
      doneOut  <= '0;
      errOut   <= '0;
      spiEnOut <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            idx          <= sel_idx;
            grantOut     <= N'(1) << sel_idx;
            spiTxDataOut <= txDataIn[sel_idx*W +: W];
            spiEnOut     <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A completion in the timeout cycle still counts as a success.
          if (spiDoneIn) begin
            rxDataOut <= spiRxDataIn;
            doneOut   <= grantOut;
            grantOut  <= '0;
            gap_cnt   <= '0;
            ptr       <= ptr_next;
            state     <= GAP;
          end else if (timeout_hit) begin
            doneOut  <= grantOut;
            errOut   <= grantOut;
            grantOut <= '0;
            gap_cnt  <= '0;
            ptr      <= ptr_next;
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: vector table of transactions plus hand-written
// sequences for reset, stray strobes and handshake corner cases.
module tb_spi_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int GAP     = 4;
  localparam int TMO     = 16;
  localparam int RW      = N + W + 1 + W;

  logic             clkIn = 1'b0;
  logic             rstIn = 1'b0;
  logic [N-1:0]     reqIn = '0;
  logic [N*W-1:0]   txDataIn = '0;
  logic [N-1:0]     grantOut;
  logic [N-1:0]     doneOut;
  logic [N-1:0]     errOut;
  logic [W-1:0]     rxDataOut;
  logic             busyOut;
  logic             spiEnOut;
  logic [W-1:0]     spiTxDataOut;
  logic [W-1:0]     spiRxDataIn = '0;
  logic             spiDoneIn = 1'b0;
  logic [1:0]       dbgState;

  spi_arbiter #(.N(N), .W(W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .reqIn(reqIn), .txDataIn(txDataIn),
    .grantOut(grantOut), .doneOut(doneOut), .errOut(errOut),
    .rxDataOut(rxDataOut), .busyOut(busyOut), .spiEnOut(spiEnOut),
    .spiTxDataOut(spiTxDataOut), .spiRxDataIn(spiRxDataIn),
    .spiDoneIn(spiDoneIn), .dbgState(dbgState)
  );

  // Clock and cycle counter
  always #5 clkIn = ~clkIn;
  int cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  // Scoreboard: {grant, tx word, err, rx word}
  logic [RW-1:0] exp_q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  logic [W-1:0]  last_rx   = '0;
  int            done_cyc  = 0;

  typedef struct {
    logic [N-1:0]   add;
    logic [N*W-1:0] tx;
    int             delay;
    logic [W-1:0]   rx;
    int             idx;
    bit             err;
    bit             drop;
    bit             gap;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clkIn);
    rstIn = 1'b1;
    reqIn = '0;
    @(negedge clkIn);
    check("rst_grant", grantOut, 0);
    check("rst_done", doneOut, 0);
    check("rst_err", errOut, 0);
    check("rst_rx", rxDataOut, 0);
    check("rst_busy", busyOut, 0);
    check("rst_spien", spiEnOut, 0);
    check("rst_spitx", spiTxDataOut, 0);
    rstIn   = 1'b0;
    last_rx = '0;
    exp_q.delete();
  endtask

  // Drives one transaction and plays the spi_master. delay = 0: never complete.
  task automatic run_txn(input logic [N-1:0] add, input logic [N*W-1:0] tx,
                         input int delay, input logic [W-1:0] rx, input int exp_idx,
                         input bit exp_err, input bit drop_early, input bit chk_gap);
    logic [N-1:0] g;
    logic [RW-1:0] rec;
    bit seen;
    int k;
    @(negedge clkIn);
    reqIn    = reqIn | add;
    txDataIn = tx;
    g = N'(1) << exp_idx;
    if (!exp_err) last_rx = rx;
    exp_q.push_back({g, tx[exp_idx*W +: W], exp_err, last_rx});

    seen = 0;
    k = 0;
    while (!seen && k < 30) begin
      if (spiEnOut) seen = 1;
      else begin
        @(negedge clkIn);
        k++;
      end
    end
    check("start_seen", seen, 1);
    rec = exp_q[0];
    check("grant", grantOut, rec[RW-1 -: N]);
    check("spi_tx", spiTxDataOut, rec[2*W -: W]);
    check("busy_start", busyOut, 1);
    if (chk_gap) check("gap_to_grant", cyc - done_cyc, GAP + 1);
    if (drop_early) reqIn = reqIn & ~g;

    seen = 0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clkIn);
      k++;
      if (k == 1) check("start_width", spiEnOut, 0);
      if (doneOut != 0 || errOut != 0) seen = 1;
      spiDoneIn   = (delay > 0 && k == delay && !seen);
      spiRxDataIn = (k == delay) ? rx : ~rx;
    end
    spiDoneIn = 1'b0;
    check("done_seen", seen, 1);
    check("done_latency", k, (delay > 0) ? delay + 1 : TMO + 1);
    rec = exp_q.pop_front();
    check("done", doneOut, rec[RW-1 -: N]);
    check("err", errOut, {N{rec[W]}} & rec[RW-1 -: N]);
    check("rx", rxDataOut, rec[W-1:0]);
    check("grant_clear", grantOut, 0);
    done_cyc = cyc;
    reqIn = reqIn & ~g;
    @(negedge clkIn);
    check("done_width", doneOut, 0);
    check("err_width", errOut, 0);
    check("busy_gap", busyOut, 1);
  endtask

  initial begin
    int j;
    logic [N*W-1:0] tx;

    vecs[0] = '{4'b1111, 32'h0, 3,  8'h11, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 32'h0, 5,  8'h22, 1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b0000, 32'h0, 1,  8'h33, 2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0000, 32'h0, 16, 8'h44, 3, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b0001, 32'h0, 2,  8'h55, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'b0101, 32'h0, 0,  8'hAA, 2, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{4'b0000, 32'h0, 7,  8'h66, 0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{4'b1000, 32'h0, 4,  8'h77, 3, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{4'b0101, 32'h0, 6,  8'h88, 0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{4'b0000, 32'h0, 9,  8'h99, 2, 1'b0, 1'b0, 1'b1};
    foreach (vecs[i]) vecs[i].tx = {$urandom, $urandom};

    do_reset();

    // Single request, then a stray spiDoneIn during GAP, then the gap length.
    run_txn(4'b0010, 32'h1234_A578, 10, 8'h3C, 1, 1'b0, 1'b0, 1'b0);
    spiRxDataIn = 8'hEE;
    spiDoneIn   = 1'b1;
    @(negedge clkIn);
    spiDoneIn = 1'b0;
    check("stray_gap_done", doneOut, 0);
    check("stray_gap_rx", rxDataOut, 8'h3C);
    j = 0;
    while (busyOut && j < 20) begin
      @(negedge clkIn);
      j++;
    end
    check("gap_len", j, 2);

    do_reset();
    foreach (vecs[i])
      run_txn(vecs[i].add, vecs[i].tx, vecs[i].delay, vecs[i].rx, vecs[i].idx,
              vecs[i].err, vecs[i].drop, vecs[i].gap);

    // Stray spiDoneIn while idle.
    repeat (6) @(negedge clkIn);
    spiRxDataIn = 8'hEE;
    spiDoneIn   = 1'b1;
    @(negedge clkIn);
    spiDoneIn = 1'b0;
    check("stray_idle_done", doneOut, 0);
    check("stray_idle_rx", rxDataOut, last_rx);
    check("stray_idle_busy", busyOut, 0);

    // Reset during WAIT: silent abort, pointer back to 0.
    @(negedge clkIn);
    tx       = {$urandom, $urandom};
    reqIn    = 4'b1000;
    txDataIn = tx;
    j = 0;
    while (!spiEnOut && j < 20) begin
      @(negedge clkIn);
      j++;
    end
    check("mid_grant", grantOut, 4'b1000);
    repeat (3) @(negedge clkIn);
    rstIn = 1'b1;
    reqIn = 4'b1001;
    @(negedge clkIn);
    check("mid_rst_grant", grantOut, 0);
    check("mid_rst_done", doneOut, 0);
    check("mid_rst_err", errOut, 0);
    check("mid_rst_busy", busyOut, 0);
    check("mid_rst_rx", rxDataOut, 0);
    rstIn   = 1'b0;
    last_rx = '0;
    run_txn(4'b0000, tx, 4, 8'hC1, 0, 1'b0, 1'b0, 1'b0);
    run_txn(4'b0000, tx, 2, 8'hC2, 3, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clkIn);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
